// File: rtl/axi4_lite_pkg.sv
// Shared types and limits for the AXI4-Lite slave memory model.
// Response codes, channel FSM states and the wait-cycle ceiling.
package axi4_lite_pkg;

  localparam int MAX_WAIT_CYC = 15;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/axi4_lite_slave_mem_ram.sv
// DEPTH x DATA_W storage: byte-enable write port, registered read port.
// A same-cycle read of the word being written returns the old contents.
module axi4_lite_slave_mem_ram
  import axi4_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     re,
  input  logic                     rzero,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = rzero ? '0 : mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// Parametrised AXI4-Lite slave memory with independent read/write FSMs.
// Define AXI_LITE_MEM_PROT_EN to reject unprivileged (AWPROT[0]=0) writes.
module axi4_lite_slave_mem
  import axi4_lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WAIT_CYC  = 0
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [2:0]          S_AXI_ARPROT,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_WAIT_CYC + 1);
  localparam bit NO_WAIT = (WAIT_CYC == 0);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * NB);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  wstate_t             wstate_q, wstate_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [2:0]          awprot_q, awprot_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  resp_t               bresp_q, bresp_d;
  logic                commit;

  rstate_t             rstate_q, rstate_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  resp_t               rresp_q, rresp_d;
  logic                sample;

  logic                prot_ok, wr_ok, rd_ok, mem_we;
  logic [IDX_W-1:0]    widx, ridx;
  logic                unused_prot;

`ifdef AXI_LITE_MEM_PROT_EN
  assign prot_ok = awprot_d[0];
`else
  assign prot_ok = 1'b1;
`endif
  assign unused_prot = ^{S_AXI_ARPROT, awprot_d};

  // Effective AW/W values: the input on the capture cycle, the register after.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    awprot_d  = awprot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wcnt_d    = wcnt_q;
    bvalid_d  = bvalid_q;
    commit    = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = S_AXI_AWADDR;
          awprot_d  = S_AXI_AWPROT;
        end
        if (S_AXI_WVALID && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if (NO_WAIT) begin
            wstate_d = W_RESP;
            commit   = 1'b1;
          end else begin
            wstate_d = W_WAIT;
            wcnt_d   = CNT_INIT;
          end
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit) bvalid_d = 1'b1;
    awready_d = (wstate_d == W_IDLE) && !aw_held_d;
    wready_d  = (wstate_d == W_IDLE) && !w_held_d;
  end

  assign wr_ok  = in_range(awaddr_d) && prot_ok;
  assign mem_we = commit && wr_ok && ARESETN;
  assign widx   = word_idx(awaddr_d);

  always_comb begin
    bresp_d = bresp_q;
    if (commit) bresp_d = wr_ok ? OKAY : SLVERR;
  end

  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    sample   = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          araddr_d = S_AXI_ARADDR;
          if (NO_WAIT) begin
            rstate_d = R_DATA;
            sample   = 1'b1;
          end else begin
            rstate_d = R_WAIT;
            rcnt_d   = CNT_INIT;
          end
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rstate_d = R_DATA;
          sample   = 1'b1;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (sample) rvalid_d = 1'b1;
    arready_d = (rstate_d == R_IDLE);
  end

  assign rd_ok = in_range(araddr_d);
  assign ridx  = word_idx(araddr_d);

  always_comb begin
    rresp_d = rresp_q;
    if (sample) rresp_d = rd_ok ? OKAY : SLVERR;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      awprot_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wcnt_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rstate_q  <= R_IDLE;
      araddr_q  <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      awprot_q  <= awprot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wcnt_q    <= wcnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      araddr_q  <= araddr_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  axi4_lite_slave_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (mem_we),
    .waddr (widx),
    .wdata (wdata_d),
    .wstrb (wstrb_d),
    .re    (sample),
    .rzero (!rd_ok),
    .raddr (ridx),
    .rdata (S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem: WAIT_CYC=0 and WAIT_CYC=3 instances.
// Prot-check expectations follow AXI_LITE_MEM_PROT_EN when it is defined.
module tb_axi4_lite_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr [2];
  logic [2:0]  awprot [2];
  logic        awvalid[2];
  logic        awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2];
  logic        bready [2];
  logic [31:0] araddr [2];
  logic [2:0]  arprot [2];
  logic        arvalid[2];
  logic        arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2];
  logic        rready [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_mem #(.WAIT_CYC(0)) u_w0 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr[0]), .S_AXI_AWPROT(awprot[0]),
    .S_AXI_AWVALID(awvalid[0]), .S_AXI_AWREADY(awready[0]),
    .S_AXI_WDATA(wdata[0]), .S_AXI_WSTRB(wstrb[0]),
    .S_AXI_WVALID(wvalid[0]), .S_AXI_WREADY(wready[0]),
    .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]),
    .S_AXI_BREADY(bready[0]),
    .S_AXI_ARADDR(araddr[0]), .S_AXI_ARPROT(arprot[0]),
    .S_AXI_ARVALID(arvalid[0]), .S_AXI_ARREADY(arready[0]),
    .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]),
    .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready[0])
  );

  axi4_lite_slave_mem #(.WAIT_CYC(3)) u_w3 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr[1]), .S_AXI_AWPROT(awprot[1]),
    .S_AXI_AWVALID(awvalid[1]), .S_AXI_AWREADY(awready[1]),
    .S_AXI_WDATA(wdata[1]), .S_AXI_WSTRB(wstrb[1]),
    .S_AXI_WVALID(wvalid[1]), .S_AXI_WREADY(wready[1]),
    .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]),
    .S_AXI_BREADY(bready[1]),
    .S_AXI_ARADDR(araddr[1]), .S_AXI_ARPROT(arprot[1]),
    .S_AXI_ARVALID(arvalid[1]), .S_AXI_ARREADY(arready[1]),
    .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]),
    .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input int d, input logic [31:0] a,
                           input logic [31:0] dt, input logic [3:0] s,
                           input logic [2:0] p, output logic [1:0] resp,
                           output int lat);
    bit aw_hs, w_hs, got;
    int n;
    awaddr[d] = a; awprot[d] = p; wdata[d] = dt; wstrb[d] = s;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b1;
    n = 0;
    while ((awvalid[d] || wvalid[d]) && n < 20) begin
      @(negedge clk);
      aw_hs = awvalid[d] && awready[d];
      w_hs  = wvalid[d] && wready[d];
      @(posedge clk); #1;
      if (aw_hs) awvalid[d] = 1'b0;
      if (w_hs)  wvalid[d]  = 1'b0;
      n++;
    end
    got = 1'b0; lat = 0; resp = 2'bxx;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (bvalid[d]) begin got = 1'b1; lat = i; resp = bresp[d]; end
    end
    chk("wr_done", 64'(got), 64'd1);
    @(posedge clk); #1;
    bready[d] = 1'b0; awvalid[d] = 1'b0; wvalid[d] = 1'b0;
  endtask

  task automatic axi_read(input int d, input logic [31:0] a,
                          output logic [31:0] dt, output logic [1:0] resp,
                          output int lat);
    bit hs, got;
    int n;
    araddr[d] = a; arprot[d] = 3'b000;
    arvalid[d] = 1'b1; rready[d] = 1'b1;
    n = 0;
    while (arvalid[d] && n < 20) begin
      @(negedge clk);
      hs = arready[d];
      @(posedge clk); #1;
      if (hs) arvalid[d] = 1'b0;
      n++;
    end
    got = 1'b0; lat = 0; resp = 2'bxx; dt = 'x;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (rvalid[d]) begin
        got = 1'b1; lat = i; resp = rresp[d]; dt = rdata[d];
      end
    end
    chk("rd_done", 64'(got), 64'd1);
    @(posedge clk); #1;
    rready[d] = 1'b0; arvalid[d] = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          lat;

    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; awprot[i] = '0; awvalid[i] = 1'b0;
      wdata[i] = '0; wstrb[i] = '0; wvalid[i] = 1'b0; bready[i] = 1'b0;
      araddr[i] = '0; arprot[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(awready[0]), 0);
    chk("rst_wready",  64'(wready[0]),  0);
    chk("rst_arready", 64'(arready[0]), 0);
    chk("rst_bvalid",  64'(bvalid[0]),  0);
    chk("rst_rvalid",  64'(rvalid[0]),  0);
    chk("rst_bresp",   64'(bresp[0]),   0);
    chk("rst_rresp",   64'(rresp[0]),   0);
    chk("rst_rdata",   64'(rdata[0]),   0);
    chk("rst_w3_arready", 64'(arready[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_awready_pre", 64'(awready[0]), 0);
    @(negedge clk);
    chk("rel_awready", 64'(awready[0]), 1);
    chk("rel_wready",  64'(wready[0]),  1);
    chk("rel_arready", 64'(arready[0]), 1);
    chk("rel_w3_awready", 64'(awready[1]), 1);

    // Full-word write then read back, with latency
    axi_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, resp, lat);
    chk("wr10_bresp", 64'(resp), 0);
    chk("wr10_lat", 64'(lat), 1);
    axi_read(0, 32'h10, data, resp, lat);
    chk("rd10_data", 64'(data), 64'hDEADBEEF);
    chk("rd10_rresp", 64'(resp), 0);
    chk("rd10_lat", 64'(lat), 1);

    // Byte-strobe merge
    axi_write(0, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b001, resp, lat);
    axi_write(0, 32'h20, 32'h00000012, 4'h1, 3'b001, resp, lat);
    chk("wr20_strb_bresp", 64'(resp), 0);
    axi_read(0, 32'h20, data, resp, lat);
    chk("rd20_data", 64'(data), 64'hFFFFFF12);

    // Unaligned address hits the containing word
    axi_read(0, 32'h13, data, resp, lat);
    chk("rd13_data", 64'(data), 64'hDEADBEEF);

    // W three cycles ahead of AW
    wdata[0] = 32'hA5A5A5A5; wstrb[0] = 4'hF;
    wvalid[0] = 1'b1; bready[0] = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", 64'(wready[0]), 1);
    @(posedge clk); #1;
    wvalid[0] = 1'b0;
    @(negedge clk);
    chk("wfirst_wready_low", 64'(wready[0]), 0);
    chk("wfirst_no_bvalid", 64'(bvalid[0]), 0);
    repeat (2) begin @(posedge clk); #1; end
    awaddr[0] = 32'h40; awprot[0] = 3'b001; awvalid[0] = 1'b1;
    @(negedge clk);
    chk("wfirst_awready", 64'(awready[0]), 1);
    chk("wfirst_bvalid_pre", 64'(bvalid[0]), 0);
    @(posedge clk); #1;
    awvalid[0] = 1'b0;
    @(negedge clk);
    chk("wfirst_bvalid", 64'(bvalid[0]), 1);
    chk("wfirst_bresp", 64'(bresp[0]), 0);
    @(posedge clk); #1;
    bready[0] = 1'b0;
    @(negedge clk);
    chk("wfirst_bvalid_clr", 64'(bvalid[0]), 0);
    chk("wfirst_ready_again", 64'({awready[0], wready[0]}), 64'd3);
    axi_read(0, 32'h40, data, resp, lat);
    chk("rd40_data", 64'(data), 64'hA5A5A5A5);

    // Out-of-range accesses and the last in-range word
    axi_write(0, 32'h0, 32'h0BADF00D, 4'hF, 3'b001, resp, lat);
    axi_read(0, 32'h1000, data, resp, lat);
    chk("rd_oor_rresp", 64'(resp), 2);
    chk("rd_oor_data", 64'(data), 0);
    axi_write(0, 32'h1000, 32'hCAFEBABE, 4'hF, 3'b001, resp, lat);
    chk("wr_oor_bresp", 64'(resp), 2);
    axi_read(0, 32'h0, data, resp, lat);
    chk("rd0_unchanged", 64'(data), 64'h0BADF00D);
    axi_write(0, 32'hFFC, 32'h5A5A0001, 4'hF, 3'b001, resp, lat);
    chk("wr_last_bresp", 64'(resp), 0);
    axi_read(0, 32'hFFC, data, resp, lat);
    chk("rd_last_data", 64'(data), 64'h5A5A0001);
    chk("rd_last_rresp", 64'(resp), 0);

    // Unprivileged write
`ifdef AXI_LITE_MEM_PROT_EN
    exp_resp = 2'b10; exp_data = 32'h0BADF00D;
`else
    exp_resp = 2'b00; exp_data = 32'h12345678;
`endif
    axi_write(0, 32'h0, 32'h12345678, 4'hF, 3'b000, resp, lat);
    chk("prot_bresp", 64'(resp), 64'(exp_resp));
    axi_read(0, 32'h0, data, resp, lat);
    chk("prot_readback", 64'(data), 64'(exp_data));

    // WAIT_CYC=3 write latency
    axi_write(1, 32'h30, 32'h11111111, 4'hF, 3'b001, resp, lat);
    chk("w3_bresp", 64'(resp), 0);
    chk("w3_wr_lat", 64'(lat), 4);

    // WAIT_CYC=3 read with RREADY held low
    araddr[1] = 32'h30; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(negedge clk);
    chk("w3_arready", 64'(arready[1]), 1);
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("w3_rvalid_early", 64'(rvalid[1]), 0);
    end
    @(negedge clk);
    chk("w3_rvalid", 64'(rvalid[1]), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("w3_hold_rdata", 64'(rdata[1]), 64'h11111111);
      chk("w3_hold_rresp", 64'(rresp[1]), 0);
      chk("w3_hold_rvalid", 64'(rvalid[1]), 1);
      chk("w3_hold_arready", 64'(arready[1]), 0);
    end
    @(posedge clk); #1;
    rready[1] = 1'b1;
    @(posedge clk); #1;
    rready[1] = 1'b0;
    @(negedge clk);
    chk("w3_rvalid_clr", 64'(rvalid[1]), 0);
    chk("w3_arready_again", 64'(arready[1]), 1);

    // Reset during the wait phase abandons the write
    awaddr[1] = 32'h30; awprot[1] = 3'b001; awvalid[1] = 1'b1;
    wdata[1] = 32'h22222222; wstrb[1] = 4'hF; wvalid[1] = 1'b1;
    bready[1] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("midrst_bvalid", 64'(bvalid[1]), 0);
    chk("midrst_awready", 64'(awready[1]), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_bvalid_after", 64'(bvalid[1]), 0);
    bready[1] = 1'b0;
    axi_read(1, 32'h30, data, resp, lat);
    chk("midrst_old_data", 64'(data), 64'h11111111);
    chk("w3_rd_lat", 64'(lat), 4);
    axi_read(0, 32'h10, data, resp, lat);
    chk("mem_survives_rst", 64'(data), 64'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_mem.md
# axi4_lite_slave_mem

Parametrised AXI4-Lite slave memory model that supersedes the fixed 32-bit, single-beat-only memory slave used in our BFM test benches. It provides configurable data width, depth, base address and response latency, independent read and write channels, byte-strobe writes and SLVERR reporting on out-of-range accesses. It attaches directly to the AXI4-Lite master BFM ports, so no tie-offs of unused AXI4 full signals are required.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits; 32 or 64 only
- DEPTH, 1024, memory size in DATA_W words; power of two
- BASE_ADDR, 32'h0, byte address of word 0; aligned to DEPTH*DATA_W/8
- WAIT_CYC, 0, extra cycles inserted between address/data acceptance and response (0..15)
- ACLK  in  1  clock; all logic is rising-edge
- ARESETN  in  1  synchronous, active-low reset
- S_AXI_AWADDR / AWPROT / AWVALID  in  ADDR_W / 3 / 1  write address channel
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA / WSTRB / WVALID  in  DATA_W / DATA_W/8 / 1  write data channel
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP / BVALID  out  2 / 1  write response; S_AXI_BREADY  in  1
- S_AXI_ARADDR / ARPROT / ARVALID  in  ADDR_W / 3 / 1  read address channel
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA / RRESP / RVALID  out  DATA_W / 2 / 1  read data channel; S_AXI_RREADY  in  1

## Operation
- Word index = (addr - BASE_ADDR) >> log2(DATA_W/8). Low address bits are ignored, so unaligned addresses access the containing word.
- An address outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8) is out of range. Out-of-range writes are dropped with BRESP=SLVERR (2'b10). Out-of-range reads return RDATA=0 with RRESP=SLVERR. In-range accesses respond OKAY (2'b00).
- Write FSM:
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W may arrive in either order or in the same cycle, and each is held in its own register.
  - When both are held: go to W_WAIT if WAIT_CYC>0, else W_RESP. W_WAIT counts down WAIT_CYC cycles, then goes to W_RESP.
  - Memory is written with per-byte WSTRB on the transition into W_RESP.
  - W_RESP: BVALID=1 until BREADY. Return to W_IDLE on the cycle BVALID&&BREADY.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake go to R_WAIT (if WAIT_CYC>0) or R_DATA.
  - Memory is sampled on the transition into R_DATA.
  - R_DATA: RVALID=1; RDATA and RRESP are held stable until RREADY. Return to R_IDLE on handshake.
- Read and write channels are fully independent. If a write commit and a read sample hit the same word in the same cycle, the read returns the old data.
- One outstanding transaction per channel. The READY signals stay low while a channel is busy.
- Memory contents are not reset; reading an unwritten word returns X.

## Timing
- During ARESETN=0: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, both FSMs in IDLE. The READY signals rise on the first cycle after ARESETN is sampled high.
- WAIT_CYC=0, AW and W in cycle 0, BREADY=1: BVALID in cycle 1, channel ready again in cycle 2.
- WAIT_CYC=0, AR in cycle 0, RREADY=1: RVALID with data in cycle 1, ARREADY high again in cycle 2.
- WAIT_CYC=N adds exactly N cycles to each of the above.
- Reset asserted mid-transaction: the in-flight transaction is abandoned. An uncommitted write does not modify memory. A write already committed stays committed.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- AXI_LITE_MEM_PROT_EN:
  - Defined: a write with AWPROT[0]=0 (unprivileged) is dropped and answered with SLVERR. Reads are unaffected.
  - Undefined: AWPROT and ARPROT are ignored.

## Structure
- Package axi4_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10
  - the write and read FSM state enums
  - the max WAIT_CYC constant
- Sub-module axi4_lite_slave_mem_ram: DEPTH x DATA_W array with one byte-enable write port and one registered read port (read-old-data on collision).

## Test plan
- Write 0xDEADBEEF to 0x10 (WSTRB=0xF), then read 0x10 -> BRESP=OKAY, RDATA=0xDEADBEEF, RRESP=OKAY.
- Write 0xFFFFFFFF to 0x20, then write 0x00000012 to 0x20 with WSTRB=0x1, then read -> 0xFFFFFF12.
- W presented 3 cycles before AW (WAIT_CYC=0) -> one write, BVALID exactly one cycle after AW accepted.
- DEPTH=1024, read 0x1000 -> RRESP=SLVERR, RDATA=0; write 0x1000 -> BRESP=SLVERR, word 0 unchanged.
- WAIT_CYC=3, RREADY held low 5 cycles -> RVALID 4 cycles after AR, RDATA/RRESP stable until RREADY.
- With AXI_LITE_MEM_PROT_EN defined, write to 0x0 with AWPROT=3'b000 -> SLVERR, readback shows the prior value.
